// File: rtl/ahbl_to_apb_pkg.sv
// ahbl_to_apb_pkg
// Shared bus-fabric definitions for the AHB-Lite to APB3 bridge.
// Holds the AHB HTRANS encodings and a small decode helper so every block
// on the fabric agrees on what counts as a real transfer.
package ahbl_to_apb_pkg;

  // AHB-Lite transfer types as driven on HTRANS
  typedef enum logic [1:0] {
    HTRANS_IDLE = 2'b00,
    HTRANS_BUSY = 2'b01,
    HTRANS_NSEQ = 2'b10,
    HTRANS_SEQ  = 2'b11
  } htrans_t;

  // NSEQ and SEQ both have bit 1 set; IDLE and BUSY never start a transfer
  function automatic logic isActiveTrans(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahbl_to_apb_if.sv
// ahbl_to_apb_if
// Bundles the AHB-Lite slave port and the APB3 master port of the bridge.
//   slave  modport : the bridge's view (takes AHB requests, drives APB)
//   master modport : the surrounding system's view (AHB master + APB peripheral)
// Signals:
//   ahbls_* : AHB-Lite address/data phase signals and HREADYOUT/HRESP/HRDATA
//   apbm_*  : APB3 PADDR/PSEL/PENABLE/PWRITE/PWDATA and PRDATA/PREADY/PSLVERR
interface ahbl_to_apb_if #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
);

  logic               ahbls_hready;
  logic               ahbls_hready_resp;
  logic               ahbls_hresp;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic               ahbls_hwrite;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize;
  logic [2:0]         ahbls_hburst;
  logic [3:0]         ahbls_hprot;
  logic               ahbls_hmastlock;
  logic [W_DATA-1:0]  ahbls_hwdata;
  logic [W_DATA-1:0]  ahbls_hrdata;

  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel;
  logic               apbm_penable;
  logic               apbm_pwrite;
  logic [W_DATA-1:0]  apbm_pwdata;
  logic [W_DATA-1:0]  apbm_prdata;
  logic               apbm_pready;
  logic               apbm_pslverr;

  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           apbm_prdata, apbm_pready, apbm_pslverr,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata
  );

  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize,
           ahbls_hburst, ahbls_hprot, ahbls_hmastlock, ahbls_hwdata,
           apbm_prdata, apbm_pready, apbm_pslverr,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
           apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata
  );

endinterface

// File: rtl/ahbl_to_apb.sv
// ahbl_to_apb
// AHB-Lite slave to APB3 master bridge, one transfer in flight at a time.
// Every AHB response and APB control output comes straight from a register,
// so PREADY never reaches HREADYOUT combinationally.
// Ports:
//   clk   : single clock shared by both buses
//   rst_n : asynchronous active-low reset
//   bus   : ahbl_to_apb_if.slave carrying the AHB-Lite and APB3 signals
module ahbl_to_apb
  import ahbl_to_apb_pkg::*;
#(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16,
  parameter int W_DATA  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  ahbl_to_apb_if.slave   bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } state_t;

  state_t             r_state;
  logic               r_hreadyResp;
  logic               r_hresp;
  logic [W_DATA-1:0]  r_hrdata;
  logic [W_PADDR-1:0] r_paddr;
  logic               r_psel;
  logic               r_penable;
  logic               r_pwrite;
  logic [W_DATA-1:0]  r_pwdata;

  logic               w_accept;
  logic               w_unused;

  // A new address phase is taken only in the states that drive HREADYOUT
  // high, which is exactly where the case statement below looks at it.
  assign w_accept = bus.ahbls_hready && isActiveTrans(bus.ahbls_htrans);

  // Size, burst, protection, lock, HTRANS[0] and the upper address bits
  // have no APB3 counterpart; peripherals are word-access only.
  assign w_unused = ^{bus.ahbls_hsize, bus.ahbls_hburst, bus.ahbls_hprot,
                      bus.ahbls_hmastlock, bus.ahbls_htrans[0],
                      bus.ahbls_haddr[W_HADDR-1:W_PADDR]};

  // Bridge FSM with registered outputs. Each branch sets the outputs the
  // next state must present, so the outputs change together with r_state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hreadyResp <= 1'b1;
      r_hresp      <= 1'b0;
      r_hrdata     <= '0;
      r_paddr      <= '0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_pwdata     <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RESP, ST_ERR2: begin
          r_hresp   <= 1'b0;
          r_penable <= 1'b0;
          if (w_accept) begin
            r_state      <= ST_SETUP;
            r_paddr      <= bus.ahbls_haddr[W_PADDR-1:0];
            r_pwrite     <= bus.ahbls_hwrite;
            r_psel       <= 1'b1;
            r_hreadyResp <= 1'b0;
          end else begin
            r_state      <= ST_IDLE;
            r_psel       <= 1'b0;
            r_hreadyResp <= 1'b1;
          end
        end
        ST_SETUP: begin
          // HWDATA is valid now that the data phase has begun
          r_pwdata  <= bus.ahbls_hwdata;
          r_penable <= 1'b1;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (bus.apbm_pready) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            if (bus.apbm_pslverr) begin
              // First cycle of the two-cycle AHB error response
              r_state <= ST_ERR1;
              r_hresp <= 1'b1;
            end else begin
              r_state      <= ST_RESP;
              r_hreadyResp <= 1'b1;
              if (!r_pwrite) begin
                r_hrdata <= bus.apbm_prdata;
              end
            end
          end
        end
        ST_ERR1: begin
          r_state      <= ST_ERR2;
          r_hreadyResp <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_hreadyResp <= 1'b1;
          r_hresp      <= 1'b0;
          r_psel       <= 1'b0;
          r_penable    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ahbls_hready_resp = r_hreadyResp;
  assign bus.ahbls_hresp       = r_hresp;
  assign bus.ahbls_hrdata      = r_hrdata;
  assign bus.apbm_paddr        = r_paddr;
  assign bus.apbm_psel         = r_psel;
  assign bus.apbm_penable      = r_penable;
  assign bus.apbm_pwrite       = r_pwrite;
  // In SETUP the write data is not registered yet, so it is passed through
  // from HWDATA; from ACCESS onward the captured copy is used.
  assign bus.apbm_pwdata       = (r_state == ST_SETUP) ? bus.ahbls_hwdata : r_pwdata;

endmodule

// File: tb/tb_ahbl_to_apb.sv
// tb_ahbl_to_apb
// Self-checking bench for ahbl_to_apb. The bench plays both the AHB master
// and the APB peripheral. Each transfer is judged against the bridge's
// cycle budget (2 wait states + 1 per APB wait + 1 on error), the APB
// address/data it must present, and the HRDATA it must hold.
module tb_ahbl_to_apb;
  import ahbl_to_apb_pkg::*;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        holdOff  = 1'b0;
  int          checks   = 0;
  int          errors   = 0;
  logic [31:0] lastRead = '0;

  ahbl_to_apb_if #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) bus ();

  ahbl_to_apb #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Single-slave system: the bus-wide HREADY follows this slave unless the
  // bench deliberately holds it low to model another slave stalling.
  assign bus.ahbls_hready = bus.ahbls_hready_resp && !holdOff;

  // Counts one comparison and reports it if the observed value differs
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Idle cycles: IDLE/BUSY HTRANS must see a zero-wait OKAY with no APB select
  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      bus.ahbls_htrans = $urandom_range(1) ? HTRANS_BUSY : HTRANS_IDLE;
      #1;
      checkOutput("idleHready", bus.ahbls_hready_resp, 1);
      checkOutput("idleHresp", bus.ahbls_hresp, 0);
      checkOutput("idlePsel", bus.apbm_psel, 0);
    end
  endtask

  // One AHB transfer. Entered just after a negedge where the bridge shows
  // HREADYOUT=1; returns at the negedge where it shows HREADYOUT=1 again,
  // so a following call pipelines its address phase into that cycle.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [31:0] rdata,
                               input int waits, input logic err);
    int   lowCycles  = 0;
    int   pselCycles = 0;
    int   penCycles  = 0;
    int   hrespLow   = 0;
    int   left       = waits;
    logic done       = 1'b0;
    logic addrOk     = 1'b1;
    logic dataOk     = 1'b1;

    bus.ahbls_htrans    = $urandom_range(1) ? HTRANS_SEQ : HTRANS_NSEQ;
    bus.ahbls_haddr     = addr;
    bus.ahbls_hwrite    = wr;
    bus.ahbls_hsize     = 3'($urandom_range(7));
    bus.ahbls_hburst    = 3'($urandom_range(7));
    bus.ahbls_hprot     = 4'($urandom_range(15));
    bus.ahbls_hmastlock = 1'($urandom_range(1));
    bus.apbm_prdata     = rdata;

    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        bus.ahbls_htrans = HTRANS_IDLE;
        bus.ahbls_hwdata = wdata;
        #1;
        if (wr) checkOutput("pwdataSetup", bus.apbm_pwdata, wdata);
      end else begin
        // The bridge must not depend on HWDATA after the first data cycle
        bus.ahbls_hwdata = $urandom;
        #1;
      end
      if (bus.ahbls_hready_resp) begin
        done = 1'b1;
      end else begin
        lowCycles++;
        if (bus.ahbls_hresp) hrespLow++;
        if (bus.apbm_psel) begin
          pselCycles++;
          if (bus.apbm_paddr !== addr[15:0] || bus.apbm_pwrite !== wr) addrOk = 1'b0;
          if (wr && bus.apbm_pwdata !== wdata) dataOk = 1'b0;
        end
        if (bus.apbm_penable) penCycles++;
        if (bus.apbm_psel && bus.apbm_penable) begin
          if (left > 0) begin
            bus.apbm_pready  = 1'b0;
            bus.apbm_pslverr = 1'($urandom_range(1));
            left--;
          end else begin
            bus.apbm_pready  = 1'b1;
            bus.apbm_pslverr = err;
          end
        end else begin
          // Outside an access phase PREADY/PSLVERR must be ignored
          bus.apbm_pready  = 1'($urandom_range(1));
          bus.apbm_pslverr = 1'($urandom_range(1));
        end
      end
    end

    if (!wr && !err) lastRead = rdata;
    checkOutput("completion", done, 1);
    checkOutput("waitStates", lowCycles, 2 + waits + (err ? 1 : 0));
    checkOutput("pselCycles", pselCycles, 2 + waits);
    checkOutput("penableCycles", penCycles, 1 + waits);
    checkOutput("hrespStall", hrespLow, err ? 1 : 0);
    checkOutput("hrespFinal", bus.ahbls_hresp, err);
    checkOutput("pselRespPhase", bus.apbm_psel, 0);
    checkOutput("apbAddrCtrl", addrOk, 1);
    checkOutput("apbWdata", dataOk, 1);
    checkOutput("hrdata", bus.ahbls_hrdata, lastRead);
  endtask

  initial begin
    logic [31:0] a;
    logic        w;
    logic        e;
    int          nw;

    bus.ahbls_htrans    = HTRANS_IDLE;
    bus.ahbls_haddr     = '0;
    bus.ahbls_hwrite    = 1'b0;
    bus.ahbls_hsize     = 3'd2;
    bus.ahbls_hburst    = 3'd0;
    bus.ahbls_hprot     = 4'd0;
    bus.ahbls_hmastlock = 1'b0;
    bus.ahbls_hwdata    = '0;
    bus.apbm_prdata     = '0;
    bus.apbm_pready     = 1'b1;
    bus.apbm_pslverr    = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    checkOutput("rstHready", bus.ahbls_hready_resp, 1);
    checkOutput("rstHresp", bus.ahbls_hresp, 0);
    checkOutput("rstHrdata", bus.ahbls_hrdata, 0);
    checkOutput("rstPsel", bus.apbm_psel, 0);
    checkOutput("rstPenable", bus.apbm_penable, 0);
    checkOutput("rstPaddr", bus.apbm_paddr, 0);
    checkOutput("rstPwrite", bus.apbm_pwrite, 0);
    checkOutput("rstPwdata", bus.apbm_pwdata, 0);
    rst_n = 1'b1;
    idleCycles(1);

    $display("[TB] directed transfers");
    applyStimulus(32'h4000_0010, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
    idleCycles(1);
    applyStimulus(32'h4000_0004, 1'b1, 32'h1234_5678, 32'h5555_AAAA, 3, 1'b0);
    idleCycles(1);
    applyStimulus(32'h4000_0008, 1'b0, 32'h0, 32'hBAD0_BAD0, 0, 1'b1);
    idleCycles(1);
    applyStimulus(32'h4000_000C, 1'b1, 32'hCAFE_F00D, 32'h1111_2222, 0, 1'b0);
    applyStimulus(32'h4000_0010, 1'b0, 32'h0, 32'h0BAD_C0DE, 0, 1'b0);
    applyStimulus(32'h4000_0014, 1'b1, 32'h7777_8888, 32'h0, 2, 1'b1);
    applyStimulus(32'h4000_0018, 1'b0, 32'h0, 32'h2468_ACE0, 1, 1'b0);

    $display("[TB] transfer with HREADY held low");
    holdOff          = 1'b1;
    bus.ahbls_htrans = HTRANS_NSEQ;
    bus.ahbls_haddr  = 32'h4000_0020;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      checkOutput("holdPsel", bus.apbm_psel, 0);
      checkOutput("holdPenable", bus.apbm_penable, 0);
      checkOutput("holdHready", bus.ahbls_hready_resp, 1);
    end
    bus.ahbls_htrans = HTRANS_IDLE;
    holdOff          = 1'b0;
    idleCycles(1);

    $display("[TB] randomized transfers");
    for (int t = 0; t < 40; t++) begin
      a  = $urandom;
      w  = 1'($urandom_range(1));
      nw = $urandom_range(4);
      e  = ($urandom_range(4) == 0);
      applyStimulus(a, w, $urandom, $urandom, nw, e);
      if ($urandom_range(1) == 0) idleCycles($urandom_range(2) + 1);
    end

    $display("[TB] reset during access");
    bus.ahbls_htrans = HTRANS_NSEQ;
    bus.ahbls_haddr  = 32'h4000_0030;
    bus.ahbls_hwrite = 1'b0;
    @(negedge clk);
    bus.ahbls_htrans = HTRANS_IDLE;
    bus.apbm_pready  = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("preRstPenable", bus.apbm_penable, 1);
    bus.apbm_pready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstPsel", bus.apbm_psel, 0);
    checkOutput("asyncRstPenable", bus.apbm_penable, 0);
    checkOutput("asyncRstHresp", bus.ahbls_hresp, 0);
    checkOutput("asyncRstHready", bus.ahbls_hready_resp, 1);
    checkOutput("asyncRstHrdata", bus.ahbls_hrdata, 0);
    @(negedge clk);
    rst_n    = 1'b1;
    lastRead = '0;
    idleCycles(2);
    applyStimulus(32'h4000_0034, 1'b0, 32'h0, 32'h1357_9BDF, 0, 1'b0);
    idleCycles(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
